// File: rtl/port_grant_ctrl_pkg.sv
// Shared types and constants for the port grant controller.
// Port indices are also used by the external fixed-priority selector.
package port_grant_ctrl_pkg;

  localparam int PORTS_DEF = 4;

  localparam int PORT_LOCAL  = 0;
  localparam int PORT_ATCLKW = 1;
  localparam int PORT_CLKW   = 2;
  localparam int PORT_BRIDGE = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SETUP     = 2'd1,
    ST_CONNECTED = 2'd2,
    ST_TEARDOWN  = 2'd3
  } state_e;

  // Width of a counter that must hold 0..n-1, never zero bits.
  function automatic int cnt_width(input int n);
    if (n > 1) return $clog2(n);
    return 1;
  endfunction

endpackage

// File: rtl/port_grant_ctrl_onehot.sv
// One-hot / all-zero classifier for a selector vector.
// A vector is one-hot when it is nonzero and has no second set bit.
module onehot_chk #(
  parameter int W = 4
) (
  input  logic [W-1:0] vec_i,
  output logic         is_onehot_o,
  output logic         is_zero_o
);

  logic [W-1:0] low_clr;

  assign low_clr     = vec_i & (vec_i - W'(1));
  assign is_zero_o   = ~|vec_i;
  assign is_onehot_o = ~is_zero_o & ~|low_clr;

endmodule

// File: rtl/port_grant_ctrl.sv
// Circuit grant FSM for one output link (IDLE/SETUP/CONNECTED/TEARDOWN).
// Optional forced release after TIMEOUT_CYCLES: define PORT_GRANT_TIMEOUT_EN.
module port_grant_ctrl
  import port_grant_ctrl_pkg::*;
#(
  parameter int PORTS          = PORTS_DEF,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [PORTS-1:0] req_i,
  output logic [PORTS-1:0] req_o,
  input  logic [PORTS-1:0] sel_i,
  input  logic             out_ready_i,
  input  logic [PORTS-1:0] release_i,
  output logic [PORTS-1:0] grant_o,
  output logic [PORTS-1:0] ack_o,
  output logic             busy_o,
  output logic             err_o,
  output logic             timeout_o
);

  state_e           state_q, state_d;
  logic [PORTS-1:0] grant_q, grant_d;
  logic             err_q, err_d;
  logic             to_q, to_d;

  logic sel_onehot;
  logic sel_zero;
  logic sel_multi;
  logic rel_hit;
  logic req_hit;

  onehot_chk #(
    .W(PORTS)
  ) u_onehot_chk (
    .vec_i      (sel_i),
    .is_onehot_o(sel_onehot),
    .is_zero_o  (sel_zero)
  );

  assign sel_multi = ~sel_onehot & ~sel_zero;
  assign rel_hit   = |(release_i & grant_q);
  assign req_hit   = |(req_i & grant_q);

`ifdef PORT_GRANT_TIMEOUT_EN
  localparam int CW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
`else
  logic to_cfg_unused;
  assign to_cfg_unused = (TIMEOUT_CYCLES != 0);
`endif

  // Next-state, grant and pulse decode
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    err_d   = 1'b0;
    to_d    = 1'b0;
`ifdef PORT_GRANT_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        if (sel_multi) begin
          err_d = 1'b1;
        end else if (out_ready_i && sel_onehot) begin
          grant_d = sel_i;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d = ST_CONNECTED;
`ifdef PORT_GRANT_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ST_CONNECTED: begin
        if (rel_hit || !req_hit) begin
          state_d = ST_TEARDOWN;
`ifdef PORT_GRANT_TIMEOUT_EN
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_TEARDOWN;
          to_d    = 1'b1;
        end else begin
          cnt_d   = cnt_q + CW'(1);
`endif
        end
      end
      ST_TEARDOWN: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, grant and pulse registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
`ifdef PORT_GRANT_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      err_q   <= err_d;
      to_q    <= to_d;
`ifdef PORT_GRANT_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign req_o     = (state_q == ST_IDLE) ? req_i : '0;
  assign grant_o   = (state_q == ST_SETUP || state_q == ST_CONNECTED)
                     ? grant_q : '0;
  assign ack_o     = (state_q == ST_SETUP) ? grant_q : '0;
  assign busy_o    = (state_q != ST_IDLE);
  assign err_o     = err_q;
  assign timeout_o = to_q;

endmodule

// File: tb/tb_port_grant_ctrl.sv
// Directed table bench for port_grant_ctrl.
// Multi-cycle corners (reset, timeout) are hand sequences.
module tb_port_grant_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_i;
  logic [3:0] req_o;
  logic [3:0] sel_i;
  logic       rdy;
  logic [3:0] rel;
  logic [3:0] grant_o;
  logic [3:0] ack_o;
  logic       busy_o;
  logic       err_o;
  logic       timeout_o;

  int total = 0;
  int bad   = 0;

  port_grant_ctrl #(
    .PORTS(4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .req_i      (req_i),
    .req_o      (req_o),
    .sel_i      (sel_i),
    .out_ready_i(rdy),
    .release_i  (rel),
    .grant_o    (grant_o),
    .ack_o      (ack_o),
    .busy_o     (busy_o),
    .err_o      (err_o),
    .timeout_o  (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] sel;
    logic       rdy;
    logic [3:0] rel;
    logic [3:0] e_reqo;
    logic [3:0] e_grant;
    logic [3:0] e_ack;
    logic       e_busy;
    logic       e_err;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic [3:0] rq, input logic [3:0] sl,
                     input logic rd, input logic [3:0] rl,
                     input logic [3:0] ero, input logic [3:0] eg,
                     input logic [3:0] ea, input logic eb,
                     input logic ee);
    vec_t v;
    v.req = rq; v.sel = sl; v.rdy = rd; v.rel = rl;
    v.e_reqo = ero; v.e_grant = eg; v.e_ack = ea;
    v.e_busy = eb; v.e_err = ee;
    tv.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [3:0] act,
                     input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%b exp=%b", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int n;
  int drops;

  initial begin
    rst_n = 1'b0;
    req_i = '0; sel_i = '0; rdy = 1'b0; rel = '0;

    //   req     sel     rdy  rel     reqo    grant   ack     busy err
    add(4'b0101,4'b0001,1'b1,4'b0000,4'b0101,4'b0001,4'b0001,1'b1,1'b0);
    add(4'b0101,4'b0000,1'b1,4'b0000,4'b0000,4'b0001,4'b0000,1'b1,1'b0);
    add(4'b0101,4'b0000,1'b1,4'b0000,4'b0000,4'b0001,4'b0000,1'b1,1'b0);
    add(4'b0101,4'b0000,1'b1,4'b0000,4'b0000,4'b0001,4'b0000,1'b1,1'b0);
    add(4'b0101,4'b0000,1'b1,4'b0000,4'b0000,4'b0001,4'b0000,1'b1,1'b0);
    add(4'b0101,4'b0000,1'b1,4'b0001,4'b0000,4'b0000,4'b0000,1'b1,1'b0);
    add(4'b0101,4'b0100,1'b1,4'b0000,4'b0000,4'b0000,4'b0000,1'b0,1'b0);
    add(4'b0101,4'b0100,1'b1,4'b0000,4'b0101,4'b0100,4'b0100,1'b1,1'b0);
    add(4'b0101,4'b0000,1'b1,4'b0000,4'b0000,4'b0100,4'b0000,1'b1,1'b0);
    add(4'b0001,4'b0000,1'b1,4'b0000,4'b0000,4'b0000,4'b0000,1'b1,1'b0);
    add(4'b0000,4'b0000,1'b1,4'b0000,4'b0000,4'b0000,4'b0000,1'b0,1'b0);
    add(4'b1010,4'b1010,1'b1,4'b0000,4'b1010,4'b0000,4'b0000,1'b0,1'b1);
    add(4'b1010,4'b0000,1'b1,4'b0000,4'b1010,4'b0000,4'b0000,1'b0,1'b0);
    add(4'b1000,4'b1000,1'b0,4'b0000,4'b1000,4'b0000,4'b0000,1'b0,1'b0);
    add(4'b1000,4'b1000,1'b0,4'b0000,4'b1000,4'b0000,4'b0000,1'b0,1'b0);
    add(4'b1000,4'b1000,1'b1,4'b0000,4'b1000,4'b1000,4'b1000,1'b1,1'b0);
    add(4'b1000,4'b0000,1'b0,4'b0010,4'b0000,4'b1000,4'b0000,1'b1,1'b0);
    add(4'b1000,4'b0000,1'b0,4'b0010,4'b0000,4'b1000,4'b0000,1'b1,1'b0);
    add(4'b0000,4'b0000,1'b0,4'b0000,4'b0000,4'b0000,4'b0000,1'b1,1'b0);
    add(4'b0000,4'b0000,1'b1,4'b0000,4'b0000,4'b0000,4'b0000,1'b0,1'b0);
    add(4'b0010,4'b0010,1'b1,4'b0000,4'b0010,4'b0010,4'b0010,1'b1,1'b0);
    add(4'b0010,4'b0000,1'b1,4'b0010,4'b0000,4'b0010,4'b0000,1'b1,1'b0);
    add(4'b0010,4'b0000,1'b1,4'b0000,4'b0000,4'b0010,4'b0000,1'b1,1'b0);
    add(4'b0010,4'b0000,1'b1,4'b0010,4'b0000,4'b0000,4'b0000,1'b1,1'b0);
    add(4'b0000,4'b0000,1'b1,4'b0000,4'b0000,4'b0000,4'b0000,1'b0,1'b0);

    tick();
    tick();
    chk("rst grant", grant_o, 4'b0000);
    chk("rst ack", ack_o, 4'b0000);
    chk("rst busy", {3'b0, busy_o}, 4'b0000);
    chk("rst err", {3'b0, err_o}, 4'b0000);
    chk("rst timeout", {3'b0, timeout_o}, 4'b0000);
    rst_n = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      req_i = tv[i].req;
      sel_i = tv[i].sel;
      rdy   = tv[i].rdy;
      rel   = tv[i].rel;
      #1;
      chk($sformatf("v%0d req_o", i), req_o, tv[i].e_reqo);
      tick();
      chk($sformatf("v%0d grant", i), grant_o, tv[i].e_grant);
      chk($sformatf("v%0d ack", i), ack_o, tv[i].e_ack);
      chk($sformatf("v%0d busy", i), {3'b0, busy_o},
          {3'b0, tv[i].e_busy});
      chk($sformatf("v%0d err", i), {3'b0, err_o},
          {3'b0, tv[i].e_err});
      chk($sformatf("v%0d timeout", i), {3'b0, timeout_o}, 4'b0000);
    end

    // Reset asserted while a circuit to CLKW is connected
    req_i = 4'b0100; sel_i = 4'b0100; rdy = 1'b1; rel = '0;
    tick();
    sel_i = '0;
    tick();
    chk("mid grant", grant_o, 4'b0100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst grant", grant_o, 4'b0000);
    chk("arst ack", ack_o, 4'b0000);
    chk("arst busy", {3'b0, busy_o}, 4'b0000);
    chk("arst err", {3'b0, err_o}, 4'b0000);
    chk("arst timeout", {3'b0, timeout_o}, 4'b0000);
    tick();
    rst_n = 1'b1;
    req_i = 4'b0001; sel_i = 4'b0001;
    tick();
    chk("post rst grant", grant_o, 4'b0001);
    chk("post rst ack", ack_o, 4'b0001);
    sel_i = '0;
    tick();
    chk("post rst conn", grant_o, 4'b0001);

`ifdef PORT_GRANT_TIMEOUT_EN
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (timeout_o && n == 0) n = k;
      if (n != 0) break;
    end
    chk("timeout cycle", 4'(n), 4'd8);
    chk("timeout grant", grant_o, 4'b0000);
    tick();
    chk("timeout pulse", {3'b0, timeout_o}, 4'b0000);
    chk("timeout idle", {3'b0, busy_o}, 4'b0000);
`else
    drops = 0;
    for (int k = 0; k < 110; k++) begin
      tick();
      if (grant_o !== 4'b0001 || timeout_o !== 1'b0) drops++;
    end
    chk("persist drops", 4'(drops), 4'd0);
    chk("persist grant", grant_o, 4'b0001);
    rel = 4'b0001;
    tick();
    rel = '0;
    chk("persist release", grant_o, 4'b0000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
